// File: rtl/wb_arbiter_pkg.sv
//------------------------------------------------------------------------------
// wb_arbiter_pkg : shared widths, source indices and round-robin helper
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wb_arbiter_pkg;
  localparam int LEN_REG_ADDR = 5;
  localparam int LEN_WORD     = 32;
  localparam int NUM_SRC      = 3;
  localparam int NUM_REG      = 1 << LEN_REG_ADDR;

  typedef logic [1:0]              src_idx_t;
  typedef logic [LEN_REG_ADDR-1:0] reg_addr_t;
  typedef logic [LEN_WORD-1:0]     word_t;

  localparam src_idx_t SRC_ALU = 2'd0;
  localparam src_idx_t SRC_LSU = 2'd1;
  localparam src_idx_t SRC_FPU = 2'd2;

  function automatic src_idx_t rr_next(input src_idx_t i);
    return (i == SRC_FPU) ? SRC_ALU : src_idx_t'(i + 2'd1);
  endfunction
endpackage

`default_nettype wire

// File: rtl/wb_slot.sv
//------------------------------------------------------------------------------
// wb_slot : one-entry holding slot for a single result source
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_slot
  import wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      i_valid,
  input  reg_addr_t i_addr,
  input  word_t     i_data,
  input  logic      i_grant,
  output logic      o_ready,
  output logic      o_occ,
  output reg_addr_t o_addr,
  output word_t     o_data
);

  logic      r_occ;
  reg_addr_t r_addr;
  word_t     r_data;

  // A slot being drained this cycle can accept its replacement at the same edge.
  assign o_ready = !r_occ || i_grant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_occ  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_valid && o_ready) begin
      r_occ  <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (i_grant) begin
      r_occ  <= 1'b0;
    end
  end

  assign o_occ  = r_occ;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
//------------------------------------------------------------------------------
// wb_arbiter : 3-source round-robin writeback arbiter with pending scoreboard
// Optional macro WB_BYPASS_EN adds two combinational bypass read ports.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [NUM_SRC-1:0]                    s_valid,
  output logic [NUM_SRC-1:0]                    s_ready,
  input  logic [NUM_SRC-1:0][LEN_REG_ADDR-1:0]  s_addr,
  input  logic [NUM_SRC-1:0][LEN_WORD-1:0]      s_data,
  input  logic                                  iss_en,
  input  logic [LEN_REG_ADDR-1:0]               iss_addr,
`ifdef WB_BYPASS_EN
  input  logic [LEN_REG_ADDR-1:0]               byp_a1,
  input  logic [LEN_REG_ADDR-1:0]               byp_a2,
  output logic                                  byp_hit1,
  output logic                                  byp_hit2,
  output logic [LEN_WORD-1:0]                   byp_d1,
  output logic [LEN_WORD-1:0]                   byp_d2,
`endif
  output logic [LEN_REG_ADDR-1:0]               ard,
  output logic [LEN_WORD-1:0]                   drd,
  output logic [NUM_REG-1:0]                    pend
);

  logic [NUM_SRC-1:0] w_occ;
  logic [NUM_SRC-1:0] w_gnt;
  reg_addr_t          w_addr [NUM_SRC];
  word_t              w_data [NUM_SRC];

  src_idx_t           r_last;
  src_idx_t           w_c0, w_c1, w_c2;
  src_idx_t           w_gidx;
  logic               w_gany;

  reg_addr_t          r_ard;
  word_t              r_drd;
  logic [NUM_REG-1:0] r_pend;
  logic [NUM_REG-1:0] w_set, w_clr, w_pend_nxt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    wb_slot u_slot (
      .clk     (clk),
      .rstn    (rstn),
      .i_valid (s_valid[g]),
      .i_addr  (s_addr[g]),
      .i_data  (s_data[g]),
      .i_grant (w_gnt[g]),
      .o_ready (s_ready[g]),
      .o_occ   (w_occ[g]),
      .o_addr  (w_addr[g]),
      .o_data  (w_data[g])
    );
  end

  // Candidate order for this cycle, starting just after the last winner.
  assign w_c0 = rr_next(r_last);
  assign w_c1 = rr_next(w_c0);
  assign w_c2 = rr_next(w_c1);

  always_comb begin
    w_gany = 1'b1;
    w_gidx = w_c0;
    if (w_occ[w_c0])      w_gidx = w_c0;
    else if (w_occ[w_c1]) w_gidx = w_c1;
    else if (w_occ[w_c2]) w_gidx = w_c2;
    else                  w_gany = 1'b0;
  end

  assign w_gnt = w_gany ? (NUM_SRC'(1) << w_gidx) : '0;

  // Set is OR-ed after clear so a same-cycle reservation survives the writeback.
  assign w_set      = (iss_en && (iss_addr != '0)) ? (NUM_REG'(1) << iss_addr) : '0;
  assign w_clr      = w_gany ? (NUM_REG'(1) << w_addr[w_gidx]) : '0;
  assign w_pend_nxt = ((r_pend & ~w_clr) | w_set) & ~NUM_REG'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ard  <= '0;
      r_drd  <= '0;
      r_pend <= '0;
      r_last <= SRC_FPU;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_gany) begin
        r_ard  <= w_addr[w_gidx];
        r_drd  <= w_data[w_gidx];
        r_last <= w_gidx;
      end else begin
        r_ard  <= '0;
      end
    end
  end

  assign ard  = r_ard;
  assign drd  = r_drd;
  assign pend = r_pend;

`ifdef WB_BYPASS_EN
  assign byp_hit1 = (r_ard != '0) && (r_ard == byp_a1);
  assign byp_hit2 = (r_ard != '0) && (r_ard == byp_a2);
  assign byp_d1   = byp_hit1 ? r_drd : '0;
  assign byp_d2   = byp_hit2 ? r_drd : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//------------------------------------------------------------------------------
// tb_wb_arbiter : directed self-checking bench for wb_arbiter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic                                 clk;
  logic                                 rstn;
  logic [NUM_SRC-1:0]                   s_valid;
  logic [NUM_SRC-1:0]                   s_ready;
  logic [NUM_SRC-1:0][LEN_REG_ADDR-1:0] s_addr;
  logic [NUM_SRC-1:0][LEN_WORD-1:0]     s_data;
  logic                                 iss_en;
  logic [LEN_REG_ADDR-1:0]              iss_addr;
  logic [LEN_REG_ADDR-1:0]              ard;
  logic [LEN_WORD-1:0]                  drd;
  logic [NUM_REG-1:0]                   pend;
`ifdef WB_BYPASS_EN
  logic [LEN_REG_ADDR-1:0]              byp_a1, byp_a2;
  logic                                 byp_hit1, byp_hit2;
  logic [LEN_WORD-1:0]                  byp_d1, byp_d2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_addr   (s_addr),
    .s_data   (s_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
`ifdef WB_BYPASS_EN
    .byp_a1   (byp_a1),
    .byp_a2   (byp_a2),
    .byp_hit1 (byp_hit1),
    .byp_hit2 (byp_hit2),
    .byp_d1   (byp_d1),
    .byp_d2   (byp_d2),
`endif
    .ard      (ard),
    .drd      (drd),
    .pend     (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_valid  = '0;
    s_addr   = '0;
    s_data   = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
`ifdef WB_BYPASS_EN
    byp_a1   = '0;
    byp_a2   = '0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    tick();
    n_cmp++; if (s_ready !== 3'b111) begin n_err++; $display("FAIL reset_ready: got %b want 111", s_ready); end
    n_cmp++; if (ard !== 5'd0) begin n_err++; $display("FAIL reset_ard: got %0d want 0", ard); end
    n_cmp++; if (drd !== 32'd0) begin n_err++; $display("FAIL reset_drd: got %h want 0", drd); end
    n_cmp++; if (pend !== 32'd0) begin n_err++; $display("FAIL reset_pend: got %h want 0", pend); end
    rstn = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    s_valid[0] = 1'b1; s_addr[0] = 5'd5; s_data[0] = 32'hDEADBEEF;
    #1;
    n_cmp++; if (s_ready[0] !== 1'b1) begin n_err++; $display("FAIL single_ready0: got %b want 1", s_ready[0]); end
    tick();                                    // cycle 1
    s_valid = '0;
    n_cmp++; if (ard !== 5'd0) begin n_err++; $display("FAIL single_c1_ard: got %0d want 0", ard); end
    tick();                                    // cycle 2
    n_cmp++; if (ard !== 5'd5) begin n_err++; $display("FAIL single_c2_ard: got %0d want 5", ard); end
    n_cmp++; if (drd !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_c2_drd: got %h want deadbeef", drd); end
    tick();                                    // cycle 3
    n_cmp++; if (ard !== 5'd0) begin n_err++; $display("FAIL single_c3_ard: got %0d want 0", ard); end
    n_cmp++; if (drd !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_c3_drd_hold: got %h want deadbeef", drd); end
  endtask

  task automatic test_contention();
    do_reset();
    s_valid = 3'b111;
    s_addr[0] = 5'd1; s_data[0] = 32'h11;
    s_addr[1] = 5'd2; s_data[1] = 32'h22;
    s_addr[2] = 5'd3; s_data[2] = 32'h33;
    tick();                                    // cycle 1: all held, src0 granted
    s_valid = '0;
    n_cmp++; if (s_ready !== 3'b001) begin n_err++; $display("FAIL cont_c1_ready: got %b want 001", s_ready); end
    tick();                                    // cycle 2
    n_cmp++; if (ard !== 5'd1) begin n_err++; $display("FAIL cont_c2_ard: got %0d want 1", ard); end
    n_cmp++; if (drd !== 32'h11) begin n_err++; $display("FAIL cont_c2_drd: got %h want 11", drd); end
    n_cmp++; if (s_ready[2] !== 1'b0) begin n_err++; $display("FAIL cont_c2_ready2: got %b want 0", s_ready[2]); end
    tick();                                    // cycle 3
    n_cmp++; if (ard !== 5'd2) begin n_err++; $display("FAIL cont_c3_ard: got %0d want 2", ard); end
    n_cmp++; if (s_ready[2] !== 1'b1) begin n_err++; $display("FAIL cont_c3_ready2: got %b want 1", s_ready[2]); end
    tick();                                    // cycle 4
    n_cmp++; if (ard !== 5'd3) begin n_err++; $display("FAIL cont_c4_ard: got %0d want 3", ard); end
    n_cmp++; if (drd !== 32'h33) begin n_err++; $display("FAIL cont_c4_drd: got %h want 33", drd); end
    tick();                                    // cycle 5
    n_cmp++; if (ard !== 5'd0) begin n_err++; $display("FAIL cont_c5_ard: got %0d want 0", ard); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();                                    // cycle 1
    iss_en = 1'b0;
    n_cmp++; if (pend !== 32'h80) begin n_err++; $display("FAIL sb_set: got %h want 80", pend); end
    s_valid[1] = 1'b1; s_addr[1] = 5'd7; s_data[1] = 32'h77;
    tick();                                    // cycle 2: slot1 held, granted
    s_valid = '0;
    n_cmp++; if (pend[7] !== 1'b1) begin n_err++; $display("FAIL sb_held: got %b want 1", pend[7]); end
    tick();                                    // cycle 3
    n_cmp++; if (ard !== 5'd7) begin n_err++; $display("FAIL sb_ard: got %0d want 7", ard); end
    n_cmp++; if (pend[7] !== 1'b0) begin n_err++; $display("FAIL sb_clr: got %b want 0", pend[7]); end
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();                                    // cycle 4
    iss_en = 1'b0;
    s_valid[1] = 1'b1;
    tick();                                    // cycle 5: grant, with same-cycle set
    s_valid = '0;
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();                                    // cycle 6
    iss_en = 1'b0;
    n_cmp++; if (ard !== 5'd7) begin n_err++; $display("FAIL sb_ard2: got %0d want 7", ard); end
    n_cmp++; if (pend !== 32'h80) begin n_err++; $display("FAIL sb_set_wins: got %h want 80", pend); end
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    iss_en = 1'b0;
    n_cmp++; if (pend !== 32'h80) begin n_err++; $display("FAIL sb_x0_iss: got %h want 80", pend); end
  endtask

  task automatic test_x0();
    // pend still holds bit 7 from the scoreboard test
    s_valid[2] = 1'b1; s_addr[2] = 5'd0; s_data[2] = 32'h1234;
    #1;
    n_cmp++; if (s_ready[2] !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", s_ready[2]); end
    tick();
    s_valid = '0;
    tick();
    n_cmp++; if (ard !== 5'd0) begin n_err++; $display("FAIL x0_ard: got %0d want 0", ard); end
    n_cmp++; if (drd !== 32'h1234) begin n_err++; $display("FAIL x0_drd: got %h want 1234", drd); end
    n_cmp++; if (pend !== 32'h80) begin n_err++; $display("FAIL x0_pend: got %h want 80", pend); end
  endtask

  task automatic test_reset_mid();
    iss_en = 1'b1; iss_addr = 5'd12;
    s_valid = 3'b011;
    s_addr[0] = 5'd10; s_data[0] = 32'hA;
    s_addr[1] = 5'd11; s_data[1] = 32'hB;
    tick();                                    // both slots now held
    s_valid = '0; iss_en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (ard !== 5'd0) begin n_err++; $display("FAIL rmid_ard: got %0d want 0", ard); end
    n_cmp++; if (pend !== 32'd0) begin n_err++; $display("FAIL rmid_pend: got %h want 0", pend); end
    n_cmp++; if (s_ready !== 3'b111) begin n_err++; $display("FAIL rmid_ready: got %b want 111", s_ready); end
    #1 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ard !== 5'd0) begin n_err++; $display("FAIL rmid_nowrite%0d: got %0d want 0", i, ard); end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    s_valid[0] = 1'b1; s_addr[0] = 5'd9; s_data[0] = 32'hCAFE;
    tick();
    s_valid = '0;
    tick();
    byp_a1 = 5'd9; byp_a2 = 5'd0;
    #1;
    n_cmp++; if (byp_hit1 !== 1'b1) begin n_err++; $display("FAIL byp_hit1: got %b want 1", byp_hit1); end
    n_cmp++; if (byp_d1 !== 32'hCAFE) begin n_err++; $display("FAIL byp_d1: got %h want cafe", byp_d1); end
    n_cmp++; if (byp_hit2 !== 1'b0) begin n_err++; $display("FAIL byp_hit2: got %b want 0", byp_hit2); end
    n_cmp++; if (byp_d2 !== 32'd0) begin n_err++; $display("FAIL byp_d2: got %h want 0", byp_d2); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_scoreboard();
    test_x0();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
